// File: rtl/urna_pkg.sv
// Shared types and constants for the urna voter-terminal ballot transmitter.
package urna_pkg;

    localparam int DIG_W = 4;

    localparam logic [DIG_W-1:0]   KEY_BLANK   = 4'hA;
    localparam logic [DIG_W-1:0]   DIG_NONE    = 4'hF;
    localparam logic [2*DIG_W-1:0] SHOWN_EMPTY = 8'hFF;

    typedef enum logic [2:0] {
        ST_D1,
        ST_D2,
        ST_REVIEW,
        ST_TX1,
        ST_GAP,
        ST_TX2,
        ST_ACK,
        ST_CLOSED
    } state_t;

    function automatic logic is_digit(input logic [DIG_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/urna_tx_timer.sv
// Loadable down-counter that times the pulse, gap and ack-wait phases.
// done is high while the count sits at zero, i.e. on the last cycle of a phase.
module urna_tx_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/urna_ballot_tx.sv
// Voter-terminal ballot collector and urna transmitter.
// Define URNA_TX_BLANK_EN to accept key 4'hA in ST_D1 as a blank ballot.
module urna_ballot_tx
    import urna_pkg::*;
#(
    parameter int PULSE_W  = 2,
    parameter int GAP_W    = 2,
    parameter int ACK_WAIT = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [DIG_W-1:0]   key_code,
    input  logic               key_correct,
    input  logic               key_confirm,
    input  logic               key_swap,
    input  logic               session_end,
    input  logic [1:0]         vote_status,
    output logic               ready,
    output logic [DIG_W-1:0]   digit,
    output logic               valid,
    output logic               swap,
    output logic               finish,
    output logic [2*DIG_W-1:0] shown,
    output logic [1:0]         last_status,
    output logic [CNT_W-1:0]   ballot_count
);

    localparam int TMR_W = 16;
    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_W - 1);
    localparam logic [TMR_W-1:0] ACK_LD   = TMR_W'(ACK_WAIT - 1);

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   d1_q, d1_d, d2_q, d2_d;
    logic               swap_req_q, swap_req_d;
    logic               pend_q, pend_d;

    logic               ready_d, valid_d, swap_d, finish_d;
    logic [DIG_W-1:0]   digit_d;
    logic [2*DIG_W-1:0] shown_d;
    logic [1:0]         last_status_d;
    logic [CNT_W-1:0]   ballot_count_d;

    logic               tmr_load, tmr_done;
    logic [TMR_W-1:0]   tmr_val;

    urna_tx_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d        = state_q;
        d1_d           = d1_q;
        d2_d           = d2_q;
        swap_req_d     = swap_req_q;
        pend_d         = pend_q;
        digit_d        = digit;
        valid_d        = valid;
        swap_d         = swap;
        shown_d        = shown;
        last_status_d  = last_status;
        ballot_count_d = ballot_count;
        tmr_load       = 1'b0;
        tmr_val        = PULSE_LD;

        // A close request during transmission waits for the ballot to finish.
        if (session_end && (state_q inside {ST_TX1, ST_GAP, ST_TX2, ST_ACK}))
            pend_d = 1'b1;

        unique case (state_q)
            ST_D1, ST_D2, ST_REVIEW: begin
                if (session_end) begin
                    state_d    = ST_CLOSED;
                    shown_d    = SHOWN_EMPTY;
                    swap_req_d = 1'b0;
                end else if (key_correct) begin
                    state_d    = ST_D1;
                    shown_d    = SHOWN_EMPTY;
                    swap_req_d = 1'b0;
                end else if (state_q == ST_REVIEW) begin
                    if (key_confirm) begin
                        state_d  = ST_TX1;
                        digit_d  = d1_q;
                        valid_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LD;
                    end else if (key_swap) begin
                        swap_req_d = ~swap_req_q;
                    end
                end else if (key_valid && is_digit(key_code)) begin
                    if (state_q == ST_D1) begin
                        d1_d    = key_code;
                        shown_d = {key_code, DIG_NONE};
                        state_d = ST_D2;
                    end else begin
                        d2_d    = key_code;
                        shown_d = {d1_q, key_code};
                        state_d = ST_REVIEW;
                    end
                end
`ifdef URNA_TX_BLANK_EN
                else if (key_valid && key_code == KEY_BLANK && state_q == ST_D1) begin
                    d1_d    = '0;
                    d2_d    = '0;
                    shown_d = '0;
                    state_d = ST_REVIEW;
                end
`endif
            end
            ST_TX1: begin
                if (tmr_done) begin
                    state_d  = ST_GAP;
                    valid_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_d  = ST_TX2;
                    digit_d  = d2_q;
                    valid_d  = 1'b1;
                    swap_d   = swap_req_q;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            ST_TX2: begin
                if (tmr_done) begin
                    state_d  = ST_ACK;
                    valid_d  = 1'b0;
                    swap_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = ACK_LD;
                end
            end
            ST_ACK: begin
                if (tmr_done) begin
                    last_status_d  = vote_status;
                    ballot_count_d = (&ballot_count) ? ballot_count : ballot_count + CNT_W'(1);
                    shown_d        = SHOWN_EMPTY;
                    swap_req_d     = 1'b0;
                    state_d        = (pend_q || session_end) ? ST_CLOSED : ST_D1;
                end
            end
            ST_CLOSED: begin
            end
        endcase

        ready_d  = state_d inside {ST_D1, ST_D2, ST_REVIEW};
        finish_d = (state_d == ST_CLOSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_D1;
            d1_q         <= '0;
            d2_q         <= '0;
            swap_req_q   <= 1'b0;
            pend_q       <= 1'b0;
            ready        <= 1'b1;
            digit        <= '0;
            valid        <= 1'b0;
            swap         <= 1'b0;
            finish       <= 1'b0;
            shown        <= SHOWN_EMPTY;
            last_status  <= '0;
            ballot_count <= '0;
        end else begin
            state_q      <= state_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            swap_req_q   <= swap_req_d;
            pend_q       <= pend_d;
            ready        <= ready_d;
            digit        <= digit_d;
            valid        <= valid_d;
            swap         <= swap_d;
            finish       <= finish_d;
            shown        <= shown_d;
            last_status  <= last_status_d;
            ballot_count <= ballot_count_d;
        end
    end

endmodule

// File: tb/tb_urna_ballot_tx.sv
// Scoreboard bench for urna_ballot_tx: a negedge monitor decodes the strobes and
// compares them against ballots queued when confirm is pressed.
module tb_urna_ballot_tx;

    localparam int PW = 2;
    localparam int GW = 2;
    localparam int AW = 8;
    localparam int CW = 2;
    localparam int K_CORR = 0;
    localparam int K_CONF = 1;
    localparam int K_SWAP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key_valid = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic          key_correct = 1'b0;
    logic          key_confirm = 1'b0;
    logic          key_swap = 1'b0;
    logic          session_end = 1'b0;
    logic [1:0]    vote_status = 2'd0;
    logic          ready, valid, swap, finish;
    logic [3:0]    digit;
    logic [7:0]    shown;
    logic [1:0]    last_status;
    logic [CW-1:0] ballot_count;

    urna_ballot_tx #(.PULSE_W(PW), .GAP_W(GW), .ACK_WAIT(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_correct  (key_correct),
        .key_confirm  (key_confirm),
        .key_swap     (key_swap),
        .session_end  (session_end),
        .vote_status  (vote_status),
        .ready        (ready),
        .digit        (digit),
        .valid        (valid),
        .swap         (swap),
        .finish       (finish),
        .shown        (shown),
        .last_status  (last_status),
        .ballot_count (ballot_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        logic       sw;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe decoder
    int         m_phase, m_run, m_gap;
    logic       m_prev, m_swbad, m_s1, m_s2;
    logic [3:0] m_d1, m_d2;
    exp_t       m_e;

    initial begin
        m_phase = 0; m_prev = 1'b0; m_swbad = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; m_prev = 1'b0; m_swbad = 1'b0;
            end else begin
                if (!valid && swap) m_swbad = 1'b1;
                if (valid && !m_prev) begin
                    if (m_phase == 0) begin
                        m_phase = 1; m_d1 = digit; m_s1 = swap; m_run = 1;
                    end else if (m_phase == 2) begin
                        chk("gap_width", m_gap, GW);
                        m_phase = 3; m_d2 = digit; m_s2 = swap; m_run = 1;
                    end
                end else if (valid) begin
                    m_run++;
                end else if (m_prev) begin
                    if (m_phase == 1) begin
                        chk("pulse1_width", m_run, PW);
                        m_phase = 2; m_gap = 1;
                    end else if (m_phase == 3) begin
                        chk("pulse2_width", m_run, PW);
                        if (sb.size() == 0) begin
                            chk("unexpected_ballot", 1, 0);
                        end else begin
                            m_e = sb.pop_front();
                            chk("digit1", m_d1, m_e.d1);
                            chk("digit2", m_d2, m_e.d2);
                            chk("swap_on_digit1", m_s1, 0);
                            chk("swap_on_digit2", m_s2, m_e.sw);
                            chk("swap_idle", m_swbad, 0);
                        end
                        m_phase = 0; m_swbad = 1'b0;
                    end
                end else if (m_phase == 2) begin
                    m_gap++;
                end
                m_prev = valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_code = c;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic hit(input int k);
        case (k)
            K_CORR:  key_correct = 1'b1;
            K_CONF:  key_confirm = 1'b1;
            default: key_swap = 1'b1;
        endcase
        tick();
        key_correct = 1'b0;
        key_confirm = 1'b0;
        key_swap = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic confirm_and_wait(input logic [3:0] d1, input logic [3:0] d2,
                                    input logic sw, input logic [1:0] st);
        int n;
        vote_status = st;
        sb.push_back('{d1, d2, sw});
        hit(K_CONF);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        chk("ballot_latency", n, 2 * PW + GW + AW);
        if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        chk("ballot_count", ballot_count, exp_cnt);
        chk("last_status", last_status, st);
        chk("shown_cleared", shown, 8'hFF);
    endtask

    task automatic ballot(input logic [3:0] d1, input logic [3:0] d2,
                          input logic sw, input logic [1:0] st);
        press(d1);
        press(d2);
        if (sw) hit(K_SWAP);
        confirm_and_wait(d1, d2, sw, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_swap", swap, 0);
        chk("rst_finish", finish, 0);
        chk("rst_digit", digit, 0);
        chk("rst_shown", shown, 8'hFF);
        chk("rst_last_status", last_status, 0);
        chk("rst_count", ballot_count, 0);

        // T1
        press(4'd1);
        chk("t1_shown_d1", shown, 8'h1F);
        press(4'd3);
        chk("t1_shown_d2", shown, 8'h13);
        chk("t1_ready_review", ready, 1);
        confirm_and_wait(4'd1, 4'd3, 1'b0, 2'b01);

        // T2
        press(4'd2);
        hit(K_CORR);
        chk("t2_shown_corrected", shown, 8'hFF);
        ballot(4'd1, 4'd3, 1'b1, 2'b10);

        // T3
        press(4'hC);
        chk("t3_code_c_ignored", shown, 8'hFF);
        press(4'd7);
        chk("t3_shown", shown, 8'h7F);
        press(4'd5);
        confirm_and_wait(4'd7, 4'd5, 1'b0, 2'b11);

        // T6: count saturates at 3 with CNT_W=2
        ballot(4'd9, 4'd0, 1'b0, 2'b00);
        ballot(4'd4, 4'd8, 1'b1, 2'b01);

`ifdef URNA_TX_BLANK_EN
        press(4'hA);
        chk("blank_shown", shown, 8'h00);
        confirm_and_wait(4'd0, 4'd0, 1'b0, 2'b10);
`else
        press(4'hA);
        chk("key_a_ignored", shown, 8'hFF);
        press(4'd2);
        chk("after_key_a", shown, 8'h2F);
        hit(K_CORR);
`endif

        // T4: close in ST_D2
        do_reset();
        press(4'd6);
        session_end = 1'b1;
        tick();
        session_end = 1'b0;
        chk("t4_finish", finish, 1);
        chk("t4_ready", ready, 0);
        press(4'd4);
        press(4'd5);
        hit(K_CONF);
        repeat (20) tick();
        chk("t4_finish_held", finish, 1);
        chk("t4_no_valid", valid, 0);
        chk("t4_count", ballot_count, 0);

        // T5: close during ST_TX1
        do_reset();
        press(4'd5);
        press(4'd8);
        vote_status = 2'b11;
        sb.push_back('{4'd5, 4'd8, 1'b0});
        hit(K_CONF);
        tick();
        session_end = 1'b1;
        tick();
        session_end = 1'b0;
        chk("t5_not_closed_yet", finish, 0);
        n = 0;
        while (!finish && n < 200) begin
            tick();
            n++;
        end
        chk("t5_finish", finish, 1);
        chk("t5_count", ballot_count, 1);
        chk("t5_last_status", last_status, 2'b11);
        chk("t5_ready", ready, 0);

        // Reset mid-transmission drops valid asynchronously
        do_reset();
        press(4'd1);
        press(4'd2);
        hit(K_CONF);
        chk("rtx_valid_high", valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rtx_valid_async_drop", valid, 0);
        chk("rtx_ready", ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) tick();
        chk("rtx_count", ballot_count, 0);
        chk("rtx_no_valid", valid, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
